// File: rtl/nn_mac_param.sv
// nn_mac_param: two-layer neural-network MAC with one time-shared multiplier.
// N_IN inputs are pre-shifted. Each input then passes through its own hidden neuron
// (w1*x + b1). The hidden outputs are summed through one output neuron
// (sum w2*h + b2), and the result is post-shifted.
// Any overflow saturates the result and records the first stage that overflowed.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | ready for a vector or a coefficient write
// PRE   | arithmetic right shift of every captured input by SH_IN
// L1    | hidden neuron idx: h[idx] = x'[idx]*W1[idx] + B1[idx]
// L2    | output neuron term idx: acc += W2[idx]*h[idx]
// BIAS  | acc += B2
// POST  | res = acc <<< SH_OUT
// DONE  | result presented until the consumer takes it
module nn_mac_param #(
    parameter int N_IN   = 2,
    parameter int DATA_W = 32,
    localparam int ADDR_W = $clog2(3*N_IN+3)
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_IN*DATA_W-1:0]   in_data,
    input  logic                     cfg_we,
    input  logic [ADDR_W-1:0]        cfg_addr,
    input  logic [DATA_W-1:0]        cfg_data,
    output logic                     cfg_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_ovf,
    output logic                     out_zero,
    output logic [2:0]               out_ovf_stage,
    output logic                     busy
);

    localparam int SH_W  = $clog2(DATA_W);
    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IN-1);
    localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_L1, S_L2, S_BIAS, S_POST, S_DONE
    } state_t;

    state_t state, state_nxt;

    logic signed [DATA_W-1:0] w1 [N_IN];
    logic signed [DATA_W-1:0] b1 [N_IN];
    logic signed [DATA_W-1:0] w2 [N_IN];
    logic signed [DATA_W-1:0] b2;
    logic [SH_W-1:0]          sh_in;
    logic [SH_W-1:0]          sh_out;

    logic signed [DATA_W-1:0] x_r [N_IN];
    logic signed [DATA_W-1:0] h_r [N_IN];
    logic signed [DATA_W-1:0] acc;
    logic [IDX_W-1:0]         idx;

    logic signed [DATA_W-1:0]   mul_a, mul_b;
    logic [2*DATA_W-1:0]        prod;
    logic [DATA_W:0]            prod_top;
    logic signed [DATA_W-1:0]   prod_lo;
    logic                       mul_ovf;
    logic signed [DATA_W-1:0]   add_a, add_b, sum;
    logic                       add_ovf;
    logic signed [DATA_W-1:0]   shifted, shifted_back;
    logic                       sh_ovf;
    logic [2:0]                 ovf_code;
    logic                       ovf_hit;

    // Full-width signed product: sign-extend both operands so the low 2*DATA_W bits are exact.
    assign prod     = {{DATA_W{mul_a[DATA_W-1]}}, mul_a} * {{DATA_W{mul_b[DATA_W-1]}}, mul_b};
    assign prod_top = prod[2*DATA_W-1:DATA_W-1];
    assign prod_lo  = prod[DATA_W-1:0];
    // The product fits only if the top DATA_W+1 bits are all copies of the sign bit.
    assign mul_ovf  = !((&prod_top) || !(|prod_top));

    assign sum     = add_a + add_b;
    assign add_ovf = (add_a[DATA_W-1] == add_b[DATA_W-1]) && (sum[DATA_W-1] != add_a[DATA_W-1]);

    // Shifting back must recover acc; otherwise a shifted-out bit or the new sign bit was lost.
    assign shifted      = acc <<< sh_out;
    assign shifted_back = shifted >>> sh_out;
    assign sh_ovf       = (shifted_back != acc);

    assign ovf_hit = (ovf_code != 3'd0);

    assign in_ready  = (state == S_IDLE);
    assign cfg_ready = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE) && (state != S_DONE);

    // Multiplier operand select: hidden layer in L1, output layer in L2.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            S_L1: begin
                mul_a = x_r[idx];
                mul_b = w1[idx];
            end
            S_L2: begin
                mul_a = h_r[idx];
                mul_b = w2[idx];
            end
            default: ;
        endcase
    end

    // Adder operand select: bias add in L1, accumulate in L2, output bias in BIAS.
    always_comb begin
        add_a = '0;
        add_b = '0;
        case (state)
            S_L1: begin
                add_a = prod_lo;
                add_b = b1[idx];
            end
            S_L2: begin
                add_a = acc;
                add_b = prod_lo;
            end
            S_BIAS: begin
                add_a = acc;
                add_b = b2;
            end
            default: ;
        endcase
    end

    // Overflow stage code for this cycle. Within one cycle, a multiply overflow takes precedence over the add that follows it.
    always_comb begin
        ovf_code = 3'd0;
        case (state)
            S_L1:   ovf_code = mul_ovf ? 3'd1 : (add_ovf ? 3'd2 : 3'd0);
            S_L2:   ovf_code = mul_ovf ? 3'd3 : (add_ovf ? 3'd4 : 3'd0);
            S_BIAS: ovf_code = add_ovf ? 3'd5 : 3'd0;
            S_POST: ovf_code = sh_ovf  ? 3'd6 : 3'd0;
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic: any overflow exits straight to DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (in_valid) state_nxt = S_PRE;
            S_PRE:  state_nxt = S_L1;
            S_L1: begin
                if (ovf_hit)              state_nxt = S_DONE;
                else if (idx == IDX_LAST) state_nxt = S_L2;
            end
            S_L2: begin
                if (ovf_hit)              state_nxt = S_DONE;
                else if (idx == IDX_LAST) state_nxt = S_BIAS;
            end
            S_BIAS: state_nxt = ovf_hit ? S_DONE : S_POST;
            S_POST: state_nxt = S_DONE;
            S_DONE: if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Coefficient file: writes land only while idle and only for mapped addresses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < N_IN; i++) begin
                w1[i] <= '0;
                b1[i] <= '0;
                w2[i] <= '0;
            end
            b2     <= '0;
            sh_in  <= '0;
            sh_out <= '0;
        end else if (cfg_we && (state == S_IDLE)) begin
            for (int i = 0; i < N_IN; i++) begin
                if (cfg_addr == ADDR_W'(i))          w1[i] <= cfg_data;
                if (cfg_addr == ADDR_W'(N_IN + i))   b1[i] <= cfg_data;
                if (cfg_addr == ADDR_W'(2*N_IN + i)) w2[i] <= cfg_data;
            end
            if (cfg_addr == ADDR_W'(3*N_IN))     b2     <= cfg_data;
            if (cfg_addr == ADDR_W'(3*N_IN + 1)) sh_in  <= cfg_data[SH_W-1:0];
            if (cfg_addr == ADDR_W'(3*N_IN + 2)) sh_out <= cfg_data[SH_W-1:0];
        end
    end

    // Datapath registers and the result/status outputs latched on entry to DONE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < N_IN; i++) begin
                x_r[i] <= '0;
                h_r[i] <= '0;
            end
            acc           <= '0;
            idx           <= '0;
            out_data      <= '0;
            out_ovf       <= 1'b0;
            out_zero      <= 1'b0;
            out_ovf_stage <= 3'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < N_IN; i++)
                            x_r[i] <= in_data[i*DATA_W +: DATA_W];
                        idx <= '0;
                    end
                end
                S_PRE: begin
                    for (int i = 0; i < N_IN; i++)
                        x_r[i] <= x_r[i] >>> sh_in;
                    acc <= '0;
                end
                S_L1: begin
                    h_r[idx] <= sum;
                    idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                end
                S_L2: begin
                    acc <= sum;
                    idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                end
                S_BIAS: acc <= sum;
                default: ;
            endcase

            if (ovf_hit) begin
                out_data      <= SAT_MAX;
                out_ovf       <= 1'b1;
                out_zero      <= 1'b0;
                out_ovf_stage <= ovf_code;
            end else if (state == S_POST) begin
                out_data      <= shifted;
                out_ovf       <= 1'b0;
                out_zero      <= (shifted == '0);
                out_ovf_stage <= 3'd0;
            end
        end
    end

endmodule
